// File: rtl/pwm_rampa_driver_if.sv
// Signal bundle between the ramp controller and the PWM driver.
// master: the controller side that drives enable/level selects.
// slave: the PWM driver side that returns the output and status.
interface pwm_rampa_driver_if;
   logic       en;
   logic       lvl_30;
   logic       lvl_50;
   logic       lvl_100;
   logic       pwm_out;
   logic [6:0] duty;
   logic       at_target;
   logic       sel_err;
   logic [1:0] state;

   modport master (
      output en, lvl_30, lvl_50, lvl_100,
      input  pwm_out, duty, at_target, sel_err, state
   );

   modport slave (
      input  en, lvl_30, lvl_50, lvl_100,
      output pwm_out, duty, at_target, sel_err, state
   );
endinterface

// File: rtl/pwm_rampa_driver.sv
// Motor PWM driver with slewed duty cycle.
// Converts one-hot speed levels (30/50/100 %) into a PWM signal whose duty
// moves by STEP % once per PWM period toward the registered target.
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | duty == 0 and target == 0
// RAMP_UP   | duty below target, rising at each period end
// RAMP_DOWN | duty above target, falling at each period end
// HOLD      | duty == target, target nonzero
module pwm_rampa_driver #(
   parameter int unsigned CLK_DIV = 10,
   parameter int unsigned STEP    = 1
) (
   input  logic            clk,
   input  logic            reset,
   pwm_rampa_driver_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      RAMP_UP   = 2'b01,
      RAMP_DOWN = 2'b10,
      HOLD      = 2'b11
   } state_t;

   localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
   localparam logic [7:0]  STEP_W     = 8'(STEP);
   localparam logic [6:0]  PHASE_LAST = 7'd99;

   logic [15:0] div_cnt;
   logic [6:0]  phase;
   logic        tick;
   logic        pb;

   logic [6:0]  target_q;
   logic [6:0]  target_d;
   logic        sel_err_q;
   logic        sel_err_d;
   logic [1:0]  sel_cnt;
   logic [6:0]  lvl_val;

   logic [6:0]  duty_q;
   logic [6:0]  duty_d;
   logic [7:0]  up_sum;
   logic [7:0]  down_gap;
   state_t      state_q;
   state_t      state_d;

   assign tick = (div_cnt == DIV_LAST);
   assign pb   = tick && (phase == PHASE_LAST);

   // PWM time base: clock divider feeding a 0..99 phase counter, both held
   // at zero while the drive is disabled so a re-enable starts a clean period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         phase   <= '0;
      end else if (!bus.en) begin
         div_cnt <= '0;
         phase   <= '0;
      end else if (tick) begin
         div_cnt <= '0;
         phase   <= (phase == PHASE_LAST) ? 7'd0 : phase + 7'd1;
      end else begin
         div_cnt <= div_cnt + 16'd1;
      end
   end

   // Level decode: anything other than exactly one select maps to 0 %;
   // more than one select is additionally flagged as an error.
   always_comb begin
      sel_cnt   = 2'({1'b0, bus.lvl_30}) + 2'({1'b0, bus.lvl_50})
                + 2'({1'b0, bus.lvl_100});
      sel_err_d = (sel_cnt > 2'd1);
      lvl_val   = 7'd0;
      if (bus.lvl_30)  lvl_val = 7'd30;
      if (bus.lvl_50)  lvl_val = 7'd50;
      if (bus.lvl_100) lvl_val = 7'd100;
      target_d  = (bus.en && sel_cnt == 2'd1) ? lvl_val : 7'd0;
   end

   // Next duty (slewed, saturating at the registered target) and the state
   // that the new duty/target pair will represent.
   always_comb begin
      duty_d   = duty_q;
      up_sum   = {1'b0, duty_q} + STEP_W;
      down_gap = {1'b0, duty_q} - {1'b0, target_q};
      if (!bus.en) begin
         duty_d = 7'd0;
      end else if (pb) begin
         if (duty_q < target_q) begin
            duty_d = (up_sum > {1'b0, target_q}) ? target_q : up_sum[6:0];
         end else if (duty_q > target_q) begin
            duty_d = (down_gap <= STEP_W) ? target_q : duty_q - STEP_W[6:0];
         end
      end

      if (duty_d < target_d) begin
         state_d = RAMP_UP;
      end else if (duty_d > target_d) begin
         state_d = RAMP_DOWN;
      end else if (target_d == 7'd0) begin
         state_d = IDLE;
      end else begin
         state_d = HOLD;
      end
   end

   // State, duty and decoded-level registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         duty_q    <= '0;
         target_q  <= '0;
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         duty_q    <= duty_d;
         target_q  <= target_d;
         sel_err_q <= sel_err_d;
      end
   end

   // en gates the output directly so a disable silences the motor at once.
   assign bus.pwm_out   = bus.en & (phase < duty_q);
   assign bus.duty      = duty_q;
   assign bus.at_target = (duty_q == target_q);
   assign bus.sel_err   = sel_err_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_pwm_rampa_driver.sv
// Bench for pwm_rampa_driver: two instances (STEP 1 and STEP 10, both with
// CLK_DIV 2, so a PWM period is 200 clocks) sharing clock and reset.
module tb_pwm_rampa_driver;

   localparam int PER = 200;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_UP   = 2'b01;
   localparam logic [1:0] S_DN   = 2'b10;
   localparam logic [1:0] S_HOLD = 2'b11;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pwm_rampa_driver_if ifa();
   pwm_rampa_driver_if ifb();

   pwm_rampa_driver #(.CLK_DIV(2), .STEP(1)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa)
   );
   pwm_rampa_driver #(.CLK_DIV(2), .STEP(10)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb)
   );

   typedef struct {
      int         w;
      logic [6:0] duty;
      logic [1:0] state;
      logic       at_t;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   function automatic logic [6:0] g_duty(input int w);
      return (w == 0) ? ifa.duty : ifb.duty;
   endfunction
   function automatic logic [1:0] g_state(input int w);
      return (w == 0) ? ifa.state : ifb.state;
   endfunction
   function automatic logic g_at(input int w);
      return (w == 0) ? ifa.at_target : ifb.at_target;
   endfunction
   function automatic logic g_pwm(input int w);
      return (w == 0) ? ifa.pwm_out : ifb.pwm_out;
   endfunction
   function automatic logic g_err(input int w);
      return (w == 0) ? ifa.sel_err : ifb.sel_err;
   endfunction

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int w, input logic e, input logic l30,
                        input logic l50, input logic l100);
      if (w == 0) begin
         ifa.en = e; ifa.lvl_30 = l30; ifa.lvl_50 = l50; ifa.lvl_100 = l100;
      end else begin
         ifb.en = e; ifb.lvl_30 = l30; ifb.lvl_50 = l50; ifb.lvl_100 = l100;
      end
   endtask

   // Called 1 time unit after an edge; releases reset 1 unit after an edge,
   // so the period boundary falls on the 200th edge after release.
   task automatic do_reset();
      #2 reset = 1'b1;
      clocks(2);
      reset = 1'b0;
   endtask

   task automatic push(input int w, input int d, input logic [1:0] st,
                       input logic at_t);
      exp_t e;
      e.w = w; e.duty = 7'(d); e.state = st; e.at_t = at_t;
      sb.push_back(e);
   endtask

   // Advance n period boundaries; `skew` clocks of the first period are
   // already spent by the caller.
   task automatic run_pbs(input int n, input int skew);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         clocks((i == 0) ? PER - skew : PER);
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: got no expected entry at boundary %0d", i);
         end else begin
            e = sb.pop_front();
            if (g_duty(e.w) !== e.duty) begin
               failures++;
               $display("FAIL pb_duty[%0d]: got %0d expected %0d", e.w, g_duty(e.w), e.duty);
            end
            checks++;
            if (g_state(e.w) !== e.state) begin
               failures++;
               $display("FAIL pb_state[%0d]: got %0d expected %0d (duty %0d)", e.w, g_state(e.w), e.state, e.duty);
            end
            checks++;
            if (g_at(e.w) !== e.at_t) begin
               failures++;
               $display("FAIL pb_at_target[%0d]: got %0b expected %0b (duty %0d)", e.w, g_at(e.w), e.at_t, e.duty);
            end
         end
      end
   endtask

   task automatic test_reset();
      drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 reset = 1'b1;
      clocks(1);
      checks++;
      if (ifa.duty !== 7'd0 || ifa.state !== S_IDLE || ifa.pwm_out !== 1'b0 ||
          ifa.at_target !== 1'b1 || ifa.sel_err !== 1'b0) begin
         failures++;
         $display("FAIL in_reset: got duty %0d state %0d pwm %0b at %0b err %0b expected 0 0 0 1 0",
                  ifa.duty, ifa.state, ifa.pwm_out, ifa.at_target, ifa.sel_err);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (ifa.state !== S_IDLE || ifa.at_target !== 1'b1 || ifa.pwm_out !== 1'b0) begin
         failures++;
         $display("FAIL after_release: got state %0d at %0b pwm %0b expected 0 1 0",
                  ifa.state, ifa.at_target, ifa.pwm_out);
      end
      clocks(1);
      checks++;
      if (ifa.state !== S_UP || ifa.at_target !== 1'b0 || ifa.duty !== 7'd0) begin
         failures++;
         $display("FAIL first_clk: got state %0d at %0b duty %0d expected 1 0 0",
                  ifa.state, ifa.at_target, ifa.duty);
      end
      clocks(PER - 2);
      checks++;
      if (ifa.duty !== 7'd0) begin
         failures++;
         $display("FAIL before_pb: got duty %0d expected 0", ifa.duty);
      end
      clocks(1);
      checks++;
      if (ifa.duty !== 7'd1 || ifa.state !== S_UP) begin
         failures++;
         $display("FAIL first_pb: got duty %0d state %0d expected 1 1", ifa.duty, ifa.state);
      end
   endtask

   task automatic test_ramp_up();
      int hi;
      drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
      do_reset();
      for (int n = 1; n <= 32; n++)
         push(0, (n < 30) ? n : 30, (n < 30) ? S_UP : S_HOLD, n >= 30);
      run_pbs(32, 0);
      checks++;
      if (ifa.pwm_out !== 1'b1) begin
         failures++;
         $display("FAIL pwm_phase0: got %0b expected 1", ifa.pwm_out);
      end
      hi = 0;
      for (int i = 0; i < PER; i++) begin
         clocks(1);
         if (ifa.pwm_out === 1'b1) hi++;
      end
      checks++;
      if (hi != 60) begin
         failures++;
         $display("FAIL high_time_30: got %0d expected 60", hi);
      end
   endtask

   task automatic test_ramp_down();
      int hi;
      drive(1, 1'b1, 1'b0, 1'b0, 1'b1);
      do_reset();
      for (int n = 1; n <= 10; n++)
         push(1, n * 10, (n < 10) ? S_UP : S_HOLD, n == 10);
      run_pbs(10, 0);
      hi = 0;
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         if (ifb.pwm_out === 1'b1) hi++;
         clocks(1);
         if (ifb.pwm_out === 1'b1) hi++;
      end
      checks++;
      if (hi != 2 * PER) begin
         failures++;
         $display("FAIL duty100_const: got %0d high samples expected %0d", hi, 2 * PER);
      end
      drive(1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int d = 90; d >= 60; d -= 10) push(1, d, S_DN, 1'b0);
      run_pbs(4, 0);
      drive(1, 1'b1, 1'b0, 1'b0, 1'b1);
      clocks(1);
      checks++;
      if (ifb.state !== S_UP || ifb.duty !== 7'd60) begin
         failures++;
         $display("FAIL reversal_clk: got state %0d duty %0d expected 1 60", ifb.state, ifb.duty);
      end
      for (int d = 70; d <= 100; d += 10) push(1, d, (d < 100) ? S_UP : S_HOLD, d == 100);
      run_pbs(4, 1);
      drive(1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int d = 90; d >= 30; d -= 10) push(1, d, (d > 30) ? S_DN : S_HOLD, d == 30);
      run_pbs(7, 0);
   endtask

   task automatic test_sel_err();
      drive(1, 1'b1, 1'b0, 1'b1, 1'b0);
      do_reset();
      for (int d = 10; d <= 50; d += 10) push(1, d, (d < 50) ? S_UP : S_HOLD, d == 50);
      run_pbs(5, 0);
      drive(1, 1'b1, 1'b1, 1'b0, 1'b1);
      #1;
      checks++;
      if (ifb.sel_err !== 1'b0) begin
         failures++;
         $display("FAIL sel_err_early: got %0b expected 0", ifb.sel_err);
      end
      clocks(1);
      checks++;
      if (ifb.sel_err !== 1'b1 || ifb.state !== S_DN || ifb.at_target !== 1'b0) begin
         failures++;
         $display("FAIL sel_err_set: got err %0b state %0d at %0b expected 1 2 0",
                  ifb.sel_err, ifb.state, ifb.at_target);
      end
      for (int d = 40; d >= 0; d -= 10) push(1, d, (d > 0) ? S_DN : S_IDLE, d == 0);
      run_pbs(5, 1);
      drive(1, 1'b1, 1'b1, 1'b0, 1'b0);
      clocks(1);
      checks++;
      if (ifb.sel_err !== 1'b0 || ifb.state !== S_UP) begin
         failures++;
         $display("FAIL sel_err_clear: got err %0b state %0d expected 0 1", ifb.sel_err, ifb.state);
      end
      for (int d = 10; d <= 30; d += 10) push(1, d, (d < 30) ? S_UP : S_HOLD, d == 30);
      run_pbs(3, 1);
   endtask

   task automatic test_enable_drop();
      drive(1, 1'b1, 1'b0, 1'b1, 1'b0);
      do_reset();
      for (int d = 10; d <= 50; d += 10) push(1, d, (d < 50) ? S_UP : S_HOLD, d == 50);
      run_pbs(5, 0);
      clocks(50);
      checks++;
      if (ifb.pwm_out !== 1'b1) begin
         failures++;
         $display("FAIL en_pre_pwm: got %0b expected 1", ifb.pwm_out);
      end
      drive(1, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (ifb.pwm_out !== 1'b0) begin
         failures++;
         $display("FAIL en_drop_pwm: got %0b expected 0", ifb.pwm_out);
      end
      clocks(1);
      checks++;
      if (ifb.duty !== 7'd0 || ifb.state !== S_IDLE || ifb.at_target !== 1'b1) begin
         failures++;
         $display("FAIL en_drop_state: got duty %0d state %0d at %0b expected 0 0 1",
                  ifb.duty, ifb.state, ifb.at_target);
      end
      clocks(20);
      checks++;
      if (ifb.duty !== 7'd0 || ifb.pwm_out !== 1'b0) begin
         failures++;
         $display("FAIL en_low_hold: got duty %0d pwm %0b expected 0 0", ifb.duty, ifb.pwm_out);
      end
      drive(1, 1'b1, 1'b0, 1'b1, 1'b0);
      push(1, 10, S_UP, 1'b0);
      push(1, 20, S_UP, 1'b0);
      run_pbs(2, 0);
   endtask

   task automatic test_async_reset();
      drive(0, 1'b1, 1'b1, 1'b0, 1'b1);
      drive(1, 1'b1, 1'b0, 1'b0, 1'b1);
      do_reset();
      for (int d = 10; d <= 30; d += 10) push(1, d, S_UP, 1'b0);
      run_pbs(3, 0);
      clocks(30);
      checks++;
      if (ifb.pwm_out !== 1'b1 || ifa.sel_err !== 1'b1) begin
         failures++;
         $display("FAIL pre_async: got pwm %0b err %0b expected 1 1", ifb.pwm_out, ifa.sel_err);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (ifb.pwm_out !== 1'b0 || ifb.duty !== 7'd0 || ifb.state !== S_IDLE ||
          ifb.at_target !== 1'b1 || ifa.sel_err !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got pwm %0b duty %0d state %0d at %0b err %0b expected 0 0 0 1 0",
                  ifb.pwm_out, ifb.duty, ifb.state, ifb.at_target, ifa.sel_err);
      end
      clocks(2);
      reset = 1'b0;
   endtask

   initial begin
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
      clocks(2);
      test_reset();
      test_ramp_up();
      test_ramp_down();
      test_sel_err();
      test_enable_drop();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_rampa_driver.md
# pwm_rampa_driver

Downstream stage of the soft-start ramp FSM. It consumes the one-hot speed-level outputs (30 %, 50 %, 100 %) and converts them into a single motor PWM signal. The duty cycle slews gradually toward the selected level rather than jumping to it. The block runs on the system clock with its own PWM time base, and its outputs drive the motor pin and the status pins of the top-level wrapper.

## Interface
Parameters:
- CLK_DIV, 10: system clocks per PWM phase step; legal range 1..65535.
- STEP, 1: duty change (in %) applied per PWM period while ramping; legal range 1..100.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  drive enable; low forces the output off.
- lvl_30  in  1  level select, 30 % duty.
- lvl_50  in  1  level select, 50 % duty.
- lvl_100  in  1  level select, 100 % duty.
- pwm_out  out  1  motor PWM output.
- duty  out  7  current duty in %, 0..100.
- at_target  out  1  duty equals the registered target.
- sel_err  out  1  more than one level select is asserted.
- state  out  2  00 IDLE, 01 RAMP_UP, 10 RAMP_DOWN, 11 HOLD.

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. tick = (div_cnt == CLK_DIV-1).
- Phase: phase counts 0..99 and advances by one on each tick, wrapping 99→0. The period boundary (pb) is a tick that occurs while phase == 99.
- Target decode, registered every clk:
  - exactly one select asserted → 30, 50 or 100;
  - no select asserted → 0;
  - two or more asserted → 0, and sel_err = 1.
  - sel_err is registered in the same clk as target and clears on the first clk the selects are valid again.
- en = 0:
  - next clk: target = 0, duty = 0, phase = 0, div_cnt = 0, state = IDLE;
  - the counters are held at 0 while en stays low;
  - sel_err still tracks the selects.
- Duty update happens only on pb, using the registered target:
  - duty < target → duty = min(duty + STEP, target);
  - duty > target → duty = max(duty − STEP, target), saturating with no underflow;
  - duty == target → no change.
- A target change mid-period takes effect at the next pb. A reversal mid-ramp turns around at the next pb without first reaching the old target.
- pwm_out = en & (phase < duty), decoded from registers.
  - duty = 0 → output constantly 0.
  - duty = 100 → output constantly 1.
- at_target = (duty == target).
- State, registered from the next-state values of duty and target:
  - IDLE: duty == 0 and target == 0.
  - RAMP_UP: duty < target.
  - RAMP_DOWN: duty > target.
  - HOLD: duty == target, target ≠ 0.
- Any reset value of STEP or CLK_DIV outside its legal range is unsupported.

## Timing
- Reset values: div_cnt 0, phase 0, duty 0, target 0, pwm_out 0, at_target 1, sel_err 0, state IDLE. Reset is asynchronous on assertion, and the first count happens on the first clk after release.
- Latencies:
  - select change → target/sel_err: 1 clk.
  - target → first duty change: at the next pb, 1..100·CLK_DIV clks later.
  - duty → pwm_out: 0 clks (combinational from registers).
- PWM period = 100·CLK_DIV clks. High time = duty·CLK_DIV clks, starting at phase 0.
- Full ramp 0→100: ceil(100/STEP) periods after the target is registered, with the first step at the next pb.
- Reset asserted mid-ramp: all registers return to reset values immediately, and pwm_out drops asynchronously.

## Test plan
- Reset/idle: assert reset with en = 1 and lvl_50 = 1, then release → duty 0, state IDLE, pwm_out 0, at_target 1. At the first pb after target = 50: duty = 1, state RAMP_UP.
- Ramp up/hold (CLK_DIV = 2, STEP = 1): en = 1, lvl_30 = 1.
  - duty increments once per 200 clks;
  - reaches 30 after 30 pbs, then state HOLD and at_target 1;
  - pwm_out is high for 60 clks of each 200-clk period.
- Ramp down/reversal (STEP = 10): settle at 100, then switch to lvl_30.
  - duty goes 90, 80, …, 30 at successive pbs with state RAMP_DOWN, then HOLD;
  - switching to lvl_100 while duty = 60 → next pb gives duty 70, state RAMP_UP.
- Select error: while in HOLD at 50, assert lvl_30 and lvl_100 together.
  - sel_err = 1 after 1 clk;
  - target 0, so duty ramps down to 0 and state reaches IDLE;
  - dropping lvl_100 → sel_err = 0 after 1 clk, and the block ramps to 30.
- Enable drop: at duty 50 mid-period, set en = 0 → pwm_out 0 immediately, next clk duty 0, phase 0, state IDLE. Raise en again → ramp restarts from 0.
- Boundary/async reset:
  - duty 100 → pwm_out constantly 1 across the phase wrap 99→0;
  - asserting reset mid-ramp between clock edges → pwm_out and all outputs return to their reset values without waiting for clk.
